// File: rtl/calc_controller.sv
// calc_controller: keypad-driven sequencer for a four-function calculator.
// Builds decimal operands from digit keys, issues one request to an external
// ALU, waits for its completion strobe (bounded by TIMEOUT) and shows the result.
module calc_controller #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic             key_is_op,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic [WIDTH-1:0] display,
    output logic             busy,
    output logic             error
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ENTRY_A = 3'd0,
        ENTRY_B = 3'd1,
        EXEC    = 3'd2,
        WAIT    = 3'd3,
        SHOW    = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_n, b_n;
    logic [1:0]       op_n;
    logic [WIDTH-1:0] res, res_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // Append a decimal digit to an accumulator; MSB of the result flags that
    // acc*10+digit no longer fits in WIDTH bits.
    function automatic logic [WIDTH:0] append_digit(input logic [WIDTH-1:0] acc,
                                                    input logic [3:0]       d);
        logic [WIDTH+3:0] ext;
        logic [WIDTH+3:0] prod;
        ext  = {4'b0000, acc};
        prod = (ext << 3) + (ext << 1) + {{WIDTH{1'b0}}, d};
        return {|prod[WIDTH+3:WIDTH], prod[WIDTH-1:0]};
    endfunction

    logic [WIDTH:0] app_a, app_b;
    assign app_a = append_digit(alu_a, key_code);
    assign app_b = append_digit(alu_b, key_code);

    logic is_digit, is_arith, is_eq, is_clr;
    assign is_digit = key_valid && !key_is_op && (key_code <= 4'd9);
    assign is_arith = key_valid &&  key_is_op && (key_code <= 4'd3);
    assign is_eq    = key_valid &&  key_is_op && (key_code == 4'd4);
    assign is_clr   = key_valid &&  key_is_op && (key_code == 4'd5);

    // State and datapath registers; reset clears everything, including data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ENTRY_A;
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            res    <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_n;
            alu_a  <= a_n;
            alu_b  <= b_n;
            alu_op <= op_n;
            res    <= res_n;
            cnt    <= cnt_n;
        end
    end

    // Next-state and next-register logic; clear overrides every state.
    always_comb begin
        state_n = state;
        a_n     = alu_a;
        b_n     = alu_b;
        op_n    = alu_op;
        res_n   = res;
        cnt_n   = '0;
        if (is_clr) begin
            state_n = ENTRY_A;
            a_n     = '0;
            b_n     = '0;
            op_n    = '0;
            res_n   = '0;
        end else begin
            case (state)
                ENTRY_A: begin
                    if (is_digit) begin
                        if (app_a[WIDTH]) state_n = ERR;
                        else              a_n     = app_a[WIDTH-1:0];
                    end else if (is_arith) begin
                        op_n    = key_code[1:0];
                        b_n     = '0;
                        state_n = ENTRY_B;
                    end
                end
                ENTRY_B: begin
                    if (is_digit) begin
                        if (app_b[WIDTH]) state_n = ERR;
                        else              b_n     = app_b[WIDTH-1:0];
                    end else if (is_arith) begin
                        op_n = key_code[1:0];
                    end else if (is_eq) begin
                        state_n = EXEC;
                    end
                end
                EXEC: begin
                    state_n = WAIT;
                end
                WAIT: begin
                    if (alu_done) begin
                        if (alu_err) begin
                            state_n = ERR;
                        end else begin
                            res_n   = alu_result;
                            state_n = SHOW;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state_n = ERR;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (is_digit) begin
                        a_n     = WIDTH'(key_code);
                        state_n = ENTRY_A;
                    end else if (is_arith) begin
                        a_n     = res;
                        op_n    = key_code[1:0];
                        b_n     = '0;
                        state_n = ENTRY_B;
                    end
                end
                ERR: begin
                    state_n = ERR;
                end
                default: begin
                    state_n = ENTRY_A;
                end
            endcase
        end
    end

    // Output decode from the registered state.
    always_comb begin
        display   = res;
        alu_start = 1'b0;
        busy      = 1'b0;
        error     = 1'b0;
        case (state)
            ENTRY_A: display   = alu_a;
            ENTRY_B: display   = alu_b;
            EXEC: begin
                alu_start = 1'b1;
                busy      = 1'b1;
            end
            WAIT:    busy      = 1'b1;
            ERR:     error     = 1'b1;
            default: display   = res;
        endcase
    end

endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: table-driven key entry checks plus hand-written ALU
// transactions, with expected ALU requests queued at stimulus time.
module tb_calc_controller;

    localparam int W  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         key_valid;
    logic         key_is_op;
    logic [3:0]   key_code;
    logic [W-1:0] alu_a, alu_b;
    logic [1:0]   alu_op;
    logic         alu_start;
    logic         alu_done;
    logic [W-1:0] alu_result;
    logic         alu_err;
    logic [W-1:0] display;
    logic         busy;
    logic         error;

    calc_controller #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .key_valid(key_valid), .key_is_op(key_is_op), .key_code(key_code),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
        .display(display), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_op;
        logic [3:0]   code;
        logic [W-1:0] e_a;
        logic [W-1:0] e_b;
        logic [1:0]   e_op;
        logic [W-1:0] e_disp;
        logic         e_err;
    } vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
    } req_t;

    localparam logic D = 1'b0;  // digit key
    localparam logic C = 1'b1;  // command key

    vec_t tbl [21];
    req_t sbq [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input logic op, input logic [3:0] code);
        key_valid = 1'b1;
        key_is_op = op;
        key_code  = code;
        cycle();
        key_valid = 1'b0;
        key_is_op = 1'b0;
        key_code  = 4'd0;
    endtask

    // Wait (bounded) for an ALU request and compare it with the queued expectation.
    task automatic wait_start(input string nm);
        req_t r;
        for (int i = 0; i < 8 && !alu_start; i++) cycle();
        if (!alu_start) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s start: got no alu_start expected a pulse", nm);
        end else if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s start: got alu_start expected no request", nm);
        end else begin
            r = sbq.pop_front();
            chk({nm, " alu_a"},  alu_a,  r.a);
            chk({nm, " alu_b"},  alu_b,  r.b);
            chk({nm, " alu_op"}, alu_op, r.op);
        end
    endtask

    task automatic alu_respond(input int dly, input logic [W-1:0] val, input logic e);
        repeat (dly) cycle();
        alu_done   = 1'b1;
        alu_result = val;
        alu_err    = e;
        cycle();
        alu_done   = 1'b0;
        alu_result = '0;
        alu_err    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; key_valid = 1'b0; key_is_op = 1'b0; key_code = 4'd0;
        alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;

        // key, a, b, op, display, error after each key
        tbl[0]  = '{D, 4'd1,  8'd1,   8'd0,  2'd0, 8'd1,   1'b0};
        tbl[1]  = '{D, 4'd2,  8'd12,  8'd0,  2'd0, 8'd12,  1'b0};
        tbl[2]  = '{D, 4'd12, 8'd12,  8'd0,  2'd0, 8'd12,  1'b0};
        tbl[3]  = '{C, 4'd4,  8'd12,  8'd0,  2'd0, 8'd12,  1'b0};
        tbl[4]  = '{C, 4'd2,  8'd12,  8'd0,  2'd2, 8'd0,   1'b0};
        tbl[5]  = '{D, 4'd7,  8'd12,  8'd7,  2'd2, 8'd7,   1'b0};
        tbl[6]  = '{C, 4'd1,  8'd12,  8'd7,  2'd1, 8'd7,   1'b0};
        tbl[7]  = '{D, 4'd3,  8'd12,  8'd73, 2'd1, 8'd73,  1'b0};
        tbl[8]  = '{D, 4'd9,  8'd12,  8'd73, 2'd1, 8'd0,   1'b1};
        tbl[9]  = '{D, 4'd1,  8'd12,  8'd73, 2'd1, 8'd0,   1'b1};
        tbl[10] = '{C, 4'd0,  8'd12,  8'd73, 2'd1, 8'd0,   1'b1};
        tbl[11] = '{C, 4'd5,  8'd0,   8'd0,  2'd0, 8'd0,   1'b0};
        tbl[12] = '{D, 4'd2,  8'd2,   8'd0,  2'd0, 8'd2,   1'b0};
        tbl[13] = '{D, 4'd5,  8'd25,  8'd0,  2'd0, 8'd25,  1'b0};
        tbl[14] = '{D, 4'd6,  8'd25,  8'd0,  2'd0, 8'd0,   1'b1};
        tbl[15] = '{C, 4'd5,  8'd0,   8'd0,  2'd0, 8'd0,   1'b0};
        tbl[16] = '{D, 4'd2,  8'd2,   8'd0,  2'd0, 8'd2,   1'b0};
        tbl[17] = '{D, 4'd5,  8'd25,  8'd0,  2'd0, 8'd25,  1'b0};
        tbl[18] = '{D, 4'd5,  8'd255, 8'd0,  2'd0, 8'd255, 1'b0};
        tbl[19] = '{D, 4'd0,  8'd255, 8'd0,  2'd0, 8'd0,   1'b1};
        tbl[20] = '{C, 4'd5,  8'd0,   8'd0,  2'd0, 8'd0,   1'b0};

        cycle();
        cycle();
        reset = 1'b0;
        chk("reset alu_a", alu_a, 0);
        chk("reset alu_b", alu_b, 0);
        chk("reset alu_op", alu_op, 0);
        chk("reset display", display, 0);
        chk("reset alu_start", alu_start, 0);
        chk("reset busy", busy, 0);
        chk("reset error", error, 0);

        for (int i = 0; i < 21; i++) begin
            press(tbl[i].is_op, tbl[i].code);
            chk($sformatf("vec%0d alu_a", i), alu_a, tbl[i].e_a);
            chk($sformatf("vec%0d alu_b", i), alu_b, tbl[i].e_b);
            chk($sformatf("vec%0d alu_op", i), alu_op, tbl[i].e_op);
            chk($sformatf("vec%0d display", i), display, tbl[i].e_disp);
            chk($sformatf("vec%0d error", i), error, tbl[i].e_err);
            chk($sformatf("vec%0d busy", i), busy, 0);
            chk($sformatf("vec%0d alu_start", i), alu_start, 0);
        end

        // 12 + 3 = 15 with a three-cycle ALU
        press(D, 4'd1); press(D, 4'd2); press(C, 4'd0); press(D, 4'd3);
        sbq.push_back('{8'd12, 8'd3, 2'd0});
        press(C, 4'd4);
        wait_start("add");
        cycle();
        chk("add start width", alu_start, 0);
        chk("add busy wait", busy, 1);
        alu_respond(2, 8'd15, 1'b0);
        chk("add display", display, 15);
        chk("add busy show", busy, 0);
        chk("add error show", error, 0);
        press(C, 4'd4);
        chk("show equals ignored", display, 15);

        // Chain from SHOW, then clear during WAIT and a late alu_done
        sbq.push_back('{8'd15, 8'd5, 2'd1});
        press(C, 4'd1);
        chk("chain alu_a", alu_a, 15);
        chk("chain alu_b cleared", alu_b, 0);
        chk("chain display", display, 0);
        press(D, 4'd5);
        press(C, 4'd4);
        wait_start("chain");
        cycle();
        chk("chain busy wait", busy, 1);
        press(C, 4'd5);
        chk("abort busy", busy, 0);
        chk("abort display", display, 0);
        alu_respond(0, 8'd99, 1'b0);
        chk("late done display", display, 0);
        chk("late done busy", busy, 0);
        chk("late done alu_a", alu_a, 0);
        press(D, 4'd4);
        chk("late done entry_a", display, 4);
        press(C, 4'd5);

        // 8 / 0 with ALU fault
        press(D, 4'd8); press(C, 4'd3); press(D, 4'd0);
        sbq.push_back('{8'd8, 8'd0, 2'd3});
        press(C, 4'd4);
        wait_start("div");
        alu_respond(1, 8'd0, 1'b1);
        chk("div error", error, 1);
        chk("div busy", busy, 0);
        press(D, 4'd7);
        chk("err digit error", error, 1);
        chk("err digit alu_a", alu_a, 8);
        press(C, 4'd5);
        chk("err clear error", error, 0);
        chk("err clear display", display, 0);

        // 4 * 5 with an ALU that never answers
        press(D, 4'd4); press(C, 4'd2); press(D, 4'd5);
        sbq.push_back('{8'd4, 8'd5, 2'd2});
        press(C, 4'd4);
        wait_start("mul");
        cycle();
        chk("mul busy wait", busy, 1);
        n = 0;
        while (!error && n < TO + 8) begin
            cycle();
            n++;
        end
        chk("timeout cycles", n, TO);
        chk("timeout error", error, 1);
        chk("timeout busy", busy, 0);
        press(C, 4'd5);

        // Reset in WAIT together with alu_done
        press(D, 4'd1); press(C, 4'd0); press(D, 4'd2);
        sbq.push_back('{8'd1, 8'd2, 2'd0});
        press(C, 4'd4);
        wait_start("rst");
        cycle();
        reset = 1'b1; alu_done = 1'b1; alu_result = 8'd77;
        cycle();
        reset = 1'b0; alu_done = 1'b0; alu_result = '0;
        chk("rst alu_a", alu_a, 0);
        chk("rst alu_b", alu_b, 0);
        chk("rst alu_op", alu_op, 0);
        chk("rst display", display, 0);
        chk("rst alu_start", alu_start, 0);
        chk("rst busy", busy, 0);
        chk("rst error", error, 0);
        press(D, 4'd3);
        chk("rst entry_a", alu_a, 3);

        chk("scoreboard empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_controller.md
CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand/result width in bits (unsigned).
REQ-002 The block SHALL have parameter TIMEOUT, default 16, setting the maximum cycles to wait for alu_done after alu_start.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_valid  input  1  one-cycle strobe qualifying key_is_op/key_code.
REQ-006 key_is_op  input  1  1 = command key, 0 = digit key.
REQ-007 key_code  input  4  digit 0-9, or command: 0 add, 1 sub, 2 mul, 3 div, 4 equals, 5 clear.
REQ-008 alu_a, alu_b  output  WIDTH each  registered operands to the ALU.
REQ-009 alu_op  output  2  registered operation code (0 add, 1 sub, 2 mul, 3 div).
REQ-010 alu_start  output  1  one-cycle request pulse to the ALU.
REQ-011 alu_done  input  1  one-cycle completion strobe from the ALU.
REQ-012 alu_result  input  WIDTH  ALU result, valid when alu_done=1.
REQ-013 alu_err  input  1  ALU fault flag (overflow, divide-by-zero), valid when alu_done=1.
REQ-014 display  output  WIDTH  value shown to the user.
REQ-015 busy  output  1  high in EXEC and WAIT.
REQ-016 error  output  1  high in ERR.

Function
REQ-017 The FSM SHALL have states ENTRY_A, ENTRY_B, EXEC, WAIT, SHOW, ERR.
REQ-018 Digit key (key_code <= 9) in ENTRY_A/ENTRY_B SHALL update the active operand to acc*10+digit; digit codes 10-15 SHALL be ignored.
REQ-019 If acc*10+digit exceeds 2^WIDTH-1, the SHALL go to ERR and the operand SHALL be unchanged.
REQ-020 display SHALL equal alu_a in ENTRY_A, alu_b in ENTRY_B, and the latched result in SHOW and ERR.
REQ-021 Operator (add..div) in ENTRY_A SHALL latch alu_op, clear alu_b, and go to ENTRY_B next cycle.
REQ-022 Operator in ENTRY_B SHALL replace alu_op and leave alu_b unchanged.
REQ-023 Equals in ENTRY_A SHALL be ignored; equals in ENTRY_B SHALL go to EXEC.
REQ-024 EXEC SHALL last one cycle with alu_start=1, then go to WAIT; alu_start SHALL be 0 in all other states.
REQ-025 In WAIT, alu_done=1 with alu_err=0 SHALL latch alu_result into display and go to SHOW; with alu_err=1, go to ERR.
REQ-026 A cycle counter SHALL start at 0 on entry to WAIT; if TIMEOUT cycles elapse without alu_done, the FSM SHALL go to ERR.
REQ-027 alu_done outside WAIT SHALL be ignored.
REQ-028 Keys other than clear SHALL be ignored in EXEC and WAIT.
REQ-029 In SHOW, a digit SHALL start a new entry: alu_a=digit, go to ENTRY_A.
REQ-030 In SHOW, an operator SHALL set alu_a=result, latch alu_op, clear alu_b, and go to ENTRY_B (chaining).
REQ-031 In SHOW, equals SHALL be ignored.
REQ-032 Clear in any state SHALL zero alu_a, alu_b, alu_op and display and go to ENTRY_A next cycle, including aborting WAIT.
REQ-033 In ERR, only clear SHALL have effect.
REQ-034 An operand in ENTRY_B SHALL NOT change alu_a.

Reset
REQ-035 When reset=1 at a clock edge, the FSM SHALL enter ENTRY_A, and alu_a, alu_b, alu_op, display, alu_start, busy, error and the timeout counter SHALL be 0.
REQ-036 Reset SHALL take priority over any simultaneous key or alu_done.

Verification
REQ-037 Keys 1,2 (digits), add, 3, equals; ALU returns 15 after 3 cycles -> alu_start one cycle with alu_a=12, alu_b=3, alu_op=0; display=15 in SHOW.
REQ-038 Digits 2,5,6 with WIDTH=8 -> display=25, then ERR with error=1; clear -> ENTRY_A, display=0.
REQ-039 Enter 8, div, 0, equals; ALU returns alu_err=1 -> ERR; following digits ignored until clear.
REQ-040 Enter 4, mul, 5, equals; ALU never asserts done -> ERR exactly TIMEOUT cycles after entering WAIT.
REQ-041 From SHOW with result 15: sub, 5, equals -> alu_a=15, alu_b=5, alu_op=1; clear during WAIT followed by late alu_done -> stays in ENTRY_A, display=0.
REQ-042 Assert reset while in WAIT with simultaneous alu_done=1 -> all outputs 0 next cycle, state ENTRY_A.
